// File: rtl/vec_pkg.sv
// Shared types and field decoder for the RVV instruction decode stage.
package vec_pkg;

   localparam logic [6:0] OP_V = 7'b1010111;

   typedef enum logic [2:0] {
      OPIVV = 3'd0,
      OPFVV = 3'd1,
      OPMVV = 3'd2,
      OPIVI = 3'd3,
      OPIVX = 3'd4,
      OPFVF = 3'd5,
      OPMVX = 3'd6,
      OPCFG = 3'd7
   } vec_funct3_e;

   typedef struct packed {
      logic [6:0]  opcode;
      logic [4:0]  vd;
      vec_funct3_e funct3;
      logic [4:0]  vs1;
      logic [4:0]  vs2;
      logic        vm;
      logic [5:0]  funct6;
      logic        illegal;
   } vec_dec_t;

   function automatic vec_dec_t vec_decode(input logic [31:0] instr);
      vec_dec_t d;
      d.opcode  = instr[6:0];
      d.vd      = instr[11:7];
      d.funct3  = vec_funct3_e'(instr[14:12]);
      d.vs1     = instr[19:15];
      d.vs2     = instr[24:20];
      d.vm      = instr[25];
      d.funct6  = instr[31:26];
      d.illegal = (instr[6:0] != OP_V);
      return d;
   endfunction

endpackage

// File: rtl/vec_dec_fifo.sv
// Synchronous FIFO with flush; head data reads as zero while empty.
module vec_dec_fifo #(
   parameter int DEPTH = 2,
   parameter int WIDTH = 8
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         flush_i,
   input  logic                         in_valid_i,
   output logic                         in_ready_o,
   input  logic [WIDTH-1:0]             in_data_i,
   output logic                         out_valid_o,
   input  logic                         out_ready_i,
   output logic [WIDTH-1:0]             out_data_o,
   output logic [$clog2(DEPTH+1)-1:0]   count_o
);
   localparam int PW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH+1);

   logic [WIDTH-1:0] mem_reg [DEPTH];
   logic [PW-1:0]    wr_ptr_reg;
   logic [PW-1:0]    rd_ptr_reg;
   logic [CW-1:0]    count_reg;
   logic [CW-1:0]    count_next;
   logic             push;
   logic             pop;

   // Ready/valid come from the count register alone, so a full queue
   // refuses a push even when the head is popped in the same cycle.
   assign in_ready_o  = (count_reg < CW'(DEPTH));
   assign out_valid_o = (count_reg != '0);
   assign push        = in_valid_i & in_ready_o;
   assign pop         = out_valid_o & out_ready_i;
   assign count_o     = count_reg;
   assign out_data_o  = out_valid_o ? mem_reg[rd_ptr_reg] : '0;

   always_comb begin
      count_next = count_reg;
      case ({push, pop})
         2'b10:   count_next = count_reg + CW'(1);
         2'b01:   count_next = count_reg - CW'(1);
         default: count_next = count_reg;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n || flush_i) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         count_reg  <= '0;
      end else begin
         if (push) wr_ptr_reg <= wr_ptr_reg + PW'(1);
         if (pop)  rd_ptr_reg <= rd_ptr_reg + PW'(1);
         count_reg <= count_next;
      end
   end

   genvar gi;
   generate
      for (gi = 0; gi < DEPTH; gi++) begin : g_entry
         always_ff @(posedge clk) begin
            if (!rst_n) begin
               mem_reg[gi] <= '0;
            end else if (!flush_i && push && (wr_ptr_reg == PW'(gi))) begin
               mem_reg[gi] <= in_data_i;
            end
         end
      end
   endgenerate

endmodule

// File: rtl/vec_instr_decoder.sv
// RVV decode stage: field split, OP-V check and output queue.
// Optional perf counters are enabled with the VEC_DECODE_PERF_EN macro.
module vec_instr_decoder #(
   parameter int TAG_WIDTH = 4,
   parameter int DEPTH     = 2
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         flush_i,
   input  logic                         in_valid_i,
   output logic                         in_ready_o,
   input  logic [31:0]                  instr_i,
   input  logic [TAG_WIDTH-1:0]         tag_i,
   output logic                         out_valid_o,
   input  logic                         out_ready_i,
   output logic [6:0]                   out_opcode_o,
   output logic [4:0]                   out_vd_o,
   output logic [2:0]                   out_funct3_o,
   output logic [4:0]                   out_vs1_o,
   output logic [4:0]                   out_vs2_o,
   output logic                         out_vm_o,
   output logic [5:0]                   out_funct6_o,
   output logic [TAG_WIDTH-1:0]         out_tag_o,
   output logic                         out_illegal_o,
   output logic [$clog2(DEPTH+1)-1:0]   count_o
`ifdef VEC_DECODE_PERF_EN
   ,
   output logic [31:0]                  perf_decoded_o,
   output logic [31:0]                  perf_illegal_o
`endif
);
   import vec_pkg::*;

   localparam int DW = $bits(vec_dec_t);
   localparam int PW = TAG_WIDTH + DW;

   vec_dec_t        in_dec;
   vec_dec_t        head_dec;
   logic [PW-1:0]   head_payload;

   assign in_dec = vec_decode(instr_i);

   vec_dec_fifo #(
      .DEPTH (DEPTH),
      .WIDTH (PW)
   ) u_fifo (
      .clk         (clk),
      .rst_n       (rst_n),
      .flush_i     (flush_i),
      .in_valid_i  (in_valid_i),
      .in_ready_o  (in_ready_o),
      .in_data_i   ({tag_i, in_dec}),
      .out_valid_o (out_valid_o),
      .out_ready_i (out_ready_i),
      .out_data_o  (head_payload),
      .count_o     (count_o)
   );

   assign head_dec      = vec_dec_t'(head_payload[DW-1:0]);
   assign out_tag_o     = head_payload[PW-1 -: TAG_WIDTH];
   assign out_opcode_o  = head_dec.opcode;
   assign out_vd_o      = head_dec.vd;
   assign out_funct3_o  = head_dec.funct3;
   assign out_vs1_o     = head_dec.vs1;
   assign out_vs2_o     = head_dec.vs2;
   assign out_vm_o      = head_dec.vm;
   assign out_funct6_o  = head_dec.funct6;
   assign out_illegal_o = head_dec.illegal;

`ifdef VEC_DECODE_PERF_EN
   logic [31:0] perf_decoded_reg;
   logic [31:0] perf_illegal_reg;
   logic        accepted;

   // A push coinciding with flush never enters the queue, so it is not counted.
   assign accepted = in_valid_i & in_ready_o & ~flush_i;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         perf_decoded_reg <= '0;
         perf_illegal_reg <= '0;
      end else if (accepted) begin
         perf_decoded_reg <= perf_decoded_reg + 32'd1;
         if (in_dec.illegal) perf_illegal_reg <= perf_illegal_reg + 32'd1;
      end
   end

   assign perf_decoded_o = perf_decoded_reg;
   assign perf_illegal_o = perf_illegal_reg;
`endif

endmodule

// File: tb/tb_vec_instr_decoder.sv
// Self-checking bench for vec_instr_decoder: vector table, corner sequences, random stream.
module tb_vec_instr_decoder;
   localparam int TW    = 4;
   localparam int DEPTH = 2;
   localparam int CW    = $clog2(DEPTH+1);

   logic          clk = 1'b0;
   logic          rst_n;
   logic          flush_i;
   logic          in_valid_i;
   logic          in_ready_o;
   logic [31:0]   instr_i;
   logic [TW-1:0] tag_i;
   logic          out_valid_o;
   logic          out_ready_i;
   logic [6:0]    out_opcode_o;
   logic [4:0]    out_vd_o;
   logic [2:0]    out_funct3_o;
   logic [4:0]    out_vs1_o;
   logic [4:0]    out_vs2_o;
   logic          out_vm_o;
   logic [5:0]    out_funct6_o;
   logic [TW-1:0] out_tag_o;
   logic          out_illegal_o;
   logic [CW-1:0] count_o;
`ifdef VEC_DECODE_PERF_EN
   logic [31:0]   perf_decoded_o;
   logic [31:0]   perf_illegal_o;
`endif

   always #5 clk = ~clk;

   vec_instr_decoder #(.TAG_WIDTH(TW), .DEPTH(DEPTH)) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .flush_i       (flush_i),
      .in_valid_i    (in_valid_i),
      .in_ready_o    (in_ready_o),
      .instr_i       (instr_i),
      .tag_i         (tag_i),
      .out_valid_o   (out_valid_o),
      .out_ready_i   (out_ready_i),
      .out_opcode_o  (out_opcode_o),
      .out_vd_o      (out_vd_o),
      .out_funct3_o  (out_funct3_o),
      .out_vs1_o     (out_vs1_o),
      .out_vs2_o     (out_vs2_o),
      .out_vm_o      (out_vm_o),
      .out_funct6_o  (out_funct6_o),
      .out_tag_o     (out_tag_o),
      .out_illegal_o (out_illegal_o),
      .count_o       (count_o)
`ifdef VEC_DECODE_PERF_EN
      ,
      .perf_decoded_o(perf_decoded_o),
      .perf_illegal_o(perf_illegal_o)
`endif
   );

   typedef struct {
      logic [31:0]   instr;
      logic [TW-1:0] tag;
      logic [6:0]    opcode;
      logic [4:0]    vd;
      logic [2:0]    funct3;
      logic [4:0]    vs1;
      logic [4:0]    vs2;
      logic          vm;
      logic [5:0]    funct6;
      logic          illegal;
   } vec_t;

   vec_t                 vecs [5];
   logic [TW+31:0]       mq [$];   // reference queue of {tag, instr}
   int                   n_checks = 0;
   int                   n_fail   = 0;
   int unsigned          m_dec    = 0;
   int unsigned          m_ill    = 0;

   task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
      end
   endtask

   function automatic logic [TW+32:0] head_now();
      return {out_tag_o, out_illegal_o, out_funct6_o, out_vm_o, out_vs2_o,
              out_vs1_o, out_funct3_o, out_vd_o, out_opcode_o};
   endfunction

   // Fields partition the word in order, so the head reassembles to the original instruction.
   function automatic logic [TW+32:0] head_exp(input logic [TW+31:0] e);
      return {e[TW+31:32], (e[6:0] != 7'b1010111), e[31:0]};
   endfunction

   task automatic check_model(input string tagname);
      int sz;
      sz = mq.size();
      chk({tagname, "_status"}, {out_valid_o, in_ready_o, count_o},
          {sz != 0, sz < DEPTH, CW'(sz)});
      chk({tagname, "_head"}, head_now(), (sz != 0) ? head_exp(mq[0]) : '0);
`ifdef VEC_DECODE_PERF_EN
      chk({tagname, "_perf"}, {perf_decoded_o, perf_illegal_o}, {m_dec, m_ill});
`endif
   endtask

   // One clock: predict from pre-edge state, update the model, check after the edge.
   task automatic step(input string tagname);
      bit push, pop;
      push = in_valid_i && (mq.size() < DEPTH);
      pop  = out_ready_i && (mq.size() > 0);
      @(posedge clk);
      if (!rst_n) begin
         mq.delete();
         m_dec = 0;
         m_ill = 0;
      end else if (flush_i) begin
         mq.delete();
      end else begin
         if (pop) void'(mq.pop_front());
         if (push) begin
            mq.push_back({tag_i, instr_i});
            m_dec++;
            if (instr_i[6:0] != 7'b1010111) m_ill++;
         end
      end
      @(negedge clk);
      check_model(tagname);
   endtask

   task automatic drive(input logic v, input logic [31:0] ins, input logic [TW-1:0] tg, input logic rdy);
      in_valid_i  = v;
      instr_i     = ins;
      tag_i       = tg;
      out_ready_i = rdy;
   endtask

   initial begin
      vecs[0] = '{32'h022081D7, 4'h5, 7'h57, 5'd3,  3'd0, 5'd1,  5'd2,  1'b1, 6'h00, 1'b0};
      vecs[1] = '{32'h00000013, 4'hA, 7'h13, 5'd0,  3'd0, 5'd0,  5'd0,  1'b0, 6'h00, 1'b1};
      vecs[2] = '{32'hB5F8E4D7, 4'h3, 7'h57, 5'd9,  3'd6, 5'd17, 5'd31, 1'b0, 6'h2D, 1'b0};
      vecs[3] = '{32'hFFFFFFFF, 4'hF, 7'h7F, 5'd31, 3'd7, 5'd31, 5'd31, 1'b1, 6'h3F, 1'b1};
      vecs[4] = '{32'h00000057, 4'h0, 7'h57, 5'd0,  3'd0, 5'd0,  5'd0,  1'b0, 6'h00, 1'b0};

      rst_n   = 1'b0;
      flush_i = 1'b0;
      drive(1'b0, 32'h0, '0, 1'b0);
      @(negedge clk);
      step("reset0");
      step("reset1");
      chk("reset_ready", {31'd0, in_ready_o}, 32'd1);
      chk("reset_valid_count", {out_valid_o, count_o}, '0);
      rst_n = 1'b1;
      step("idle");

      // Vector table: one-cycle latency, field split, illegal still delivered.
      for (int i = 0; i < 5; i++) begin
         drive(1'b1, vecs[i].instr, vecs[i].tag, 1'b1);
         step($sformatf("vec%0d_push", i));
         drive(1'b0, 32'h0, '0, 1'b1);
         chk($sformatf("vec%0d_valid", i), {63'd0, out_valid_o}, 64'd1);
         chk($sformatf("vec%0d_fields", i), head_now(),
             {vecs[i].tag, vecs[i].illegal, vecs[i].funct6, vecs[i].vm, vecs[i].vs2,
              vecs[i].vs1, vecs[i].funct3, vecs[i].vd, vecs[i].opcode});
         $display("vec %0d: instr=0x%08h tag=%0h -> opcode=%0h vd=%0d f3=%0d vs1=%0d vs2=%0d vm=%0d f6=%0h ill=%0d",
                  i, vecs[i].instr, vecs[i].tag, out_opcode_o, out_vd_o, out_funct3_o,
                  out_vs1_o, out_vs2_o, out_vm_o, out_funct6_o, out_illegal_o);
         step($sformatf("vec%0d_pop", i));
      end

      // Backpressure: three pushes into a 2-deep queue with the consumer stalled.
      drive(1'b1, 32'h11111057, 4'h1, 1'b0);
      step("bp_a");
      drive(1'b1, 32'h22222057, 4'h2, 1'b0);
      step("bp_b");
      chk("bp_full_ready", {63'd0, in_ready_o}, 64'd0);
      chk("bp_full_count", {62'd0, count_o}, 64'd2);
      drive(1'b1, 32'h33333057, 4'h3, 1'b0);
      step("bp_c0");
      step("bp_c1");
      chk("bp_head_stable", head_now(), {4'h1, 1'b0, 32'h11111057});
      $display("backpressure: count=%0d in_ready=%0d head_tag=%0h", count_o, in_ready_o, out_tag_o);

      // FULL with pop and push together: pop happens, push waits a cycle.
      out_ready_i = 1'b1;
      step("full_pop");
      chk("full_pop_head", head_now(), {4'h2, 1'b0, 32'h22222057});
      chk("full_pop_count", {62'd0, count_o}, 64'd1);
      step("full_push");
      chk("full_push_head", head_now(), {4'h3, 1'b0, 32'h33333057});
      $display("full pop/push: count=%0d head_tag=%0h", count_o, out_tag_o);

      // Streaming through pointer wrap at one per cycle.
      for (int k = 0; k < 8; k++) begin
         drive(1'b1, {$urandom_range(255, 0), 24'h000057} | (32'(k) << 7), 4'(k + 4), 1'b1);
         step($sformatf("wrap%0d", k));
         $display("wrap %0d: head instr=0x%08h tag=%0h", k,
                  {out_funct6_o, out_vm_o, out_vs2_o, out_vs1_o, out_funct3_o, out_vd_o, out_opcode_o}, out_tag_o);
      end
      drive(1'b0, 32'h0, '0, 1'b1);
      step("drain0");
      step("drain1");
      chk("drain_empty", {63'd0, out_valid_o}, 64'd0);

      // Flush with a same-cycle push.
      drive(1'b1, 32'hAAAA0057, 4'h6, 1'b0);
      step("fl_a");
      drive(1'b1, 32'hBBBB0013, 4'h7, 1'b0);
      step("fl_b");
      flush_i = 1'b1;
      drive(1'b1, 32'hCCCC0057, 4'h8, 1'b0);
      step("flush");
      flush_i = 1'b0;
      drive(1'b0, 32'h0, '0, 1'b1);
      chk("flush_count", {62'd0, count_o}, 64'd0);
      chk("flush_fields", head_now(), '0);
      step("post_flush");
      chk("post_flush_valid", {63'd0, out_valid_o}, 64'd0);
      $display("flush: count=%0d out_valid=%0d", count_o, out_valid_o);

      // Reset mid-stream with one entry queued.
      drive(1'b1, 32'hDDDD0057, 4'h9, 1'b0);
      step("rs_a");
      rst_n = 1'b0;
      drive(1'b1, 32'hEEEE0057, 4'hA, 1'b1);
      step("midreset");
      chk("midreset_state", {out_valid_o, in_ready_o, count_o}, {1'b0, 1'b1, CW'(0)});
      chk("midreset_fields", head_now(), '0);
      rst_n = 1'b1;
      drive(1'b0, 32'h0, '0, 1'b0);
      step("after_reset");
      $display("mid-stream reset: count=%0d in_ready=%0d", count_o, in_ready_o);

      // Random stream against the reference queue.
      for (int c = 0; c < 400; c++) begin
         logic [31:0] ins;
         ins = $urandom();
         if ($urandom_range(1, 0) == 1) ins[6:0] = 7'b1010111;
         flush_i = ($urandom_range(39, 0) == 0);
         drive(($urandom_range(3, 0) != 0), ins, 4'($urandom_range(15, 0)),
               ($urandom_range(2, 0) != 0));
         step($sformatf("rand%0d", c));
         $display("rand %0d: count=%0d out_valid=%0d head_tag=%0h ill=%0d",
                  c, count_o, out_valid_o, out_tag_o, out_illegal_o);
      end
      flush_i = 1'b0;

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/vec_instr_decoder.md
# vec_instr_decoder

Parametrised vector-instruction decode stage for the vector core front end. Accepts raw 32-bit RVV instructions with a sideband tag over a valid/ready handshake and splits them into register, function and mask fields. Flags instructions that are not OP-V, and buffers the decoded results in a DEPTH-entry output queue. Sits between instruction fetch and the vector register-file read stage, and supports a pipeline flush.

## Interface
- `TAG_WIDTH`, default 4: width of the sideband instruction tag carried with each instruction; must be ≥1.
- `DEPTH`, default 2: output queue entries; power of two, ≥2.
- `clk` in 1: clock.
- `rst_n` in 1: reset, synchronous, active-low.
- `flush_i` in 1: discards all queued entries.
- `in_valid_i` in 1: instruction offered.
- `in_ready_o` out 1: decoder can accept.
- `instr_i` in 32: raw instruction word.
- `tag_i` in TAG_WIDTH: sideband tag.
- `out_valid_o` out 1: head entry valid.
- `out_ready_i` in 1: consumer takes the head entry.
- `out_opcode_o` out 7: bits [6:0].
- `out_vd_o` out 5: bits [11:7].
- `out_funct3_o` out 3: bits [14:12].
- `out_vs1_o` out 5: bits [19:15].
- `out_vs2_o` out 5: bits [24:20].
- `out_vm_o` out 1: bit [25].
- `out_funct6_o` out 6: bits [31:26].
- `out_tag_o` out TAG_WIDTH: tag of the head entry.
- `out_illegal_o` out 1: head opcode ≠ OP_V (7'b1010111).
- `count_o` out $clog2(DEPTH+1): current occupancy.

## Operation
- Push when `in_valid_i & in_ready_o`. Fields are decoded combinationally from `instr_i` and written with the tag and illegal flag at the write pointer.
- Pop when `out_valid_o & out_ready_i`; the read pointer advances.
- Illegal instructions are not dropped. They are queued with `out_illegal_o`=1.
- Occupancy states:
  - EMPTY: count=0.
  - PARTIAL: 0<count<DEPTH.
  - FULL: count=DEPTH.
- Transitions:
  - Push only: count+1.
  - Pop only: count−1.
  - Push and pop in the same cycle: count unchanged.
- Pointers are $clog2(DEPTH) bits and wrap naturally from DEPTH−1 to 0.
- `in_ready_o` = (count < DEPTH). There is no combinational path from `out_ready_i`, so no push occurs while FULL, even if a pop happens in the same cycle.
- `out_valid_o` = (count ≠ 0). All `out_*` field, tag and illegal outputs are forced to 0 while `out_valid_o`=0.
- Flush: `flush_i`=1 at an edge sets count and both pointers to 0. A same-cycle push or pop is ignored. Flush has priority below reset.
- Reset values: count 0, pointers 0, storage 0, `out_valid_o` 0, all fields 0, `in_ready_o` 1.

## Timing
- Latency: an instruction accepted at edge N appears on `out_*` after edge N when the queue was empty (one cycle).
- All outputs are registered or derived from registers only. `in_ready_o` and `out_valid_o` have no combinational dependence on the `*_valid_i` or `*_ready_i` inputs.
- Sustained throughput: 1 instruction/cycle when `out_ready_i` is held at 1.
- `out_*` must stay stable while `out_valid_o`=1 and `out_ready_i`=0.
- `instr_i` and `tag_i` are only sampled on a push.

## Configuration
- `VEC_DECODE_PERF_EN` defined: adds output ports `perf_decoded_o` [31:0] and `perf_illegal_o` [31:0].
  - `perf_decoded_o` increments on every push.
  - `perf_illegal_o` increments on every push with an illegal opcode.
  - Both wrap at 2^32, reset to 0, and are unaffected by flush.
- Not defined: neither the ports nor the counter logic exist.

## Structure
- Package `vec_pkg` holds:
  - Constant `OP_V`.
  - Enum `vec_funct3_e`: OPIVV=0, OPFVV=1, OPMVV=2, OPIVI=3, OPIVX=4, OPFVF=5, OPMVX=6, OPCFG=7.
  - Struct `vec_dec_t` with fields opcode, vd, funct3, vs1, vs2, vm, funct6, illegal.
- Sub-module `vec_dec_fifo`: generic synchronous FIFO parametrised on DEPTH and payload width, with flush. The top level holds the decode logic and the perf counters.

## Test plan
- Reset, then push 0x022081D7 with tag 5 while `out_ready_i`=1. Expected one cycle later: opcode 0x57, vd 3, funct3 0, vs1 1, vs2 2, vm 1, funct6 0, tag 5, illegal 0.
- Push 0x00000013 (OP-IMM). Expected: `out_illegal_o`=1 and the entry is still delivered; with the macro defined, `perf_illegal_o`=1.
- DEPTH=2 with `out_ready_i`=0 and three back-to-back pushes. Expected: `in_ready_o`=0 after two pushes, count=2, the third instruction is held off, and outputs stay stable.
- With FULL, raise `out_ready_i` and `in_valid_i` together. Expected: the pop occurs and the push is refused that cycle. The push is accepted the next cycle, and order is preserved through pointer wrap over 8 instructions.
- With 2 entries queued, assert `flush_i` together with `in_valid_i`. Expected: count=0, `out_valid_o`=0, all fields 0, and the flushed-cycle instruction is not queued.
- Assert `rst_n`=0 mid-stream with 1 entry queued. Expected: all outputs at their reset values after the edge, and perf counters at 0.
